decode_fold: RTL and testbench
==============================

# decode_fold

Registered, run-length-folding decode stage for the bfX core, sitting between instruction fetch and execute. It classifies each instruction with the same opcode map as the combinational decoder. Consecutive identical pointer-move or data-modify instructions are merged into one operation carrying a repeat count, so execute applies `>>>>` or `+++` in a single step. It uses valid/ready handshakes on both sides and halts after issuing STOP.

## Interface
Parameters:
- `IW` = 8: instruction width; only `ix[3:0]` are decoded, `ix[IW-1:4]` are ignored.
- `CW` = 8: repeat-count width; the maximum fold is `2^CW - 1`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents `in_ix`.
- `in_ix`  in  IW  instruction.
- `in_ready`  out  1  block accepts `in_ix` this cycle; combinational.
- `out_valid`  out  1  decoded op is presented.
- `out_ready`  in  1  execute accepts the op.
- `out_op`  out  3  class: 0 PTR, 1 DATA, 2 IO, 3 BRANCH, 4 STOP, 7 ILLEGAL.
- `out_mode`  out  1  `ix[0]` of the op.
- `out_count`  out  CW  repeat count, ≥1.
- `halted`  out  1  STOP has been issued.

## Operation
- Classification of `ix[3:0]`:
  - 0x0/0x1 → PTR (foldable).
  - 0x2/0x3 → DATA (foldable).
  - 0x4/0x5 → IO.
  - 0x6/0x7 → BRANCH.
  - 0x8 → STOP.
  - 0x9–0xF → ILLEGAL.
  - Mode is `ix[0]`; for STOP and ILLEGAL, `out_mode` is 0.
- Compatibility: an incoming instruction is compatible when it is foldable with the same class and same mode as the accumulated op. `+` followed by `-` is not compatible; no net arithmetic is performed.
- Internal accumulator: `acc_op`, `acc_mode`, `acc_count`. Outputs are driven directly from the accumulator.
- IDLE:
  - `in_ready=1`, `out_valid=0`.
  - Accepted foldable instruction → ACC, count=1.
  - Accepted non-foldable instruction → EMIT, count=1.
- ACC:
  - `in_ready = in_valid & compatible & (acc_count != MAX)`.
  - Compatible accept → count+1. If the new count equals MAX → EMIT.
  - Incompatible `in_valid` → EMIT; the instruction is not accepted and stays at the input.
  - `in_valid=0` (bubble) → EMIT.
  - `out_valid=0`.
- EMIT:
  - `out_valid=1`; outputs are held stable until `out_ready`.
  - `in_ready = out_ready & (acc_op != STOP)`.
  - On `out_ready` with `in_valid`: the new instruction loads the accumulator directly (→ ACC or EMIT), with no idle cycle.
  - On `out_ready` without `in_valid` → IDLE.
  - On `out_ready` with `acc_op == STOP` → HALT.
- HALT:
  - `in_ready=0`, `out_valid=0`, `halted=1`.
  - Left only by reset.
- Count arithmetic: modulo-free. The count never exceeds `2^CW - 1`; saturation forces emit, and the next compatible instruction starts a new run at 1.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State becomes IDLE; `out_valid=0`, `halted=0`, `out_op=0`, `out_mode=0`, `out_count=0`.
  - `in_ready` is forced to 0 while `rst_n` is low.
- Reset mid-ACC or mid-EMIT discards the accumulated op. Nothing is emitted after release.
- Latency: a non-foldable op accepted at edge N has `out_valid` high after edge N.
- A folded run is emitted one cycle after its terminating event (incompatible input, bubble, or saturation).
- Throughput:
  - Back-to-back non-foldable ops run at 1 op/cycle when `out_ready` is held high.
  - A foldable run of k instructions costs k cycles plus 1 emit cycle.
- Handshake: once `out_valid` is high, `out_op`, `out_mode` and `out_count` are stable until the `out_valid & out_ready` edge.

## Test plan
- Fold with bubble: 0x03,0x03,0x03 back-to-back, then `in_valid=0` → exactly one output {DATA, mode 1, count 3}.
- Saturation (CW=4): 16 × 0x01 contiguous → {PTR,1,15} then {PTR,1,1}. `in_ready` is low in the saturating cycle.
- Mode break: 0x03,0x02,0x00 contiguous → {DATA,1,1}, {DATA,0,1}, {PTR,0,1}. The incompatible instruction is held by `in_ready=0` and not lost.
- Backpressure: 0x05,0x05,0x07 with `out_ready=0` for 3 cycles, then 1 → three outputs {IO,1,1},{IO,1,1},{BRANCH,1,1}, with outputs stable while stalled.
- Stop/illegal: 0x0A,0x08,0x02 → {ILLEGAL,0,1}, {STOP,0,1}, then `halted=1` and `in_ready=0`. 0x02 is never accepted.
- Async reset: assert `rst_n=0` mid-edge during ACC holding count 2 → `out_valid=0` and `in_ready=0` immediately. After release, the first output is from new input only.

Source files
------------

// File: rtl/decode_fold.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// decode_fold
// Registered decode stage between fetch and execute for the bfX core.
// Classifies ix[3:0] with the core opcode map and folds runs of identical
// pointer-move / data-modify instructions into a single op with a repeat
// count. Valid/ready handshakes on both sides; stops issuing after STOP.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   fetch presents in_ix
//   in_ix      instruction (only [3:0] decoded)
//   in_ready   instruction accepted this cycle (combinational)
//   out_valid  decoded op presented
//   out_ready  execute accepts the op
//   out_op     class: 0 PTR, 1 DATA, 2 IO, 3 BRANCH, 4 STOP, 7 ILLEGAL
//   out_mode   ix[0] of the op (0 for STOP / ILLEGAL)
//   out_count  repeat count
//   halted     STOP has been issued
// -----------------------------------------------------------------------------
module decode_fold #(
  parameter int IW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_ix,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_op,
  output logic          out_mode,
  output logic [CW-1:0] out_count,
  output logic          halted
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [2:0] OP_PTR     = 3'd0;
  localparam logic [2:0] OP_DATA    = 3'd1;
  localparam logic [2:0] OP_IO      = 3'd2;
  localparam logic [2:0] OP_BRANCH  = 3'd3;
  localparam logic [2:0] OP_STOP    = 3'd4;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  // Opcode map shared with the combinational decoder.
  function automatic logic [2:0] classify(input logic [3:0] nib);
    logic [2:0] op;
    case (nib[3:1])
      3'd0:    op = OP_PTR;
      3'd1:    op = OP_DATA;
      3'd2:    op = OP_IO;
      3'd3:    op = OP_BRANCH;
      3'd4:    op = nib[0] ? OP_ILLEGAL : OP_STOP;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  function automatic logic is_foldable(input logic [2:0] op);
    return (op == OP_PTR) || (op == OP_DATA);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [2:0]    acc_op_q, acc_op_d;
  logic          acc_mode_q, acc_mode_d;
  logic [CW-1:0] acc_count_q, acc_count_d;
  logic          out_valid_q, halted_q;

  logic [2:0]    new_op_s;
  logic          new_mode_s;
  logic          compat_s;
  logic          in_ready_s;
  logic          ix_unused_s;

  // Upper instruction bits carry no decode information.
  assign ix_unused_s = ^in_ix[IW-1:4];

  // Classify the incoming instruction and compute next state / accumulator.
  always_comb begin
    new_op_s    = classify(in_ix[3:0]);
    // Only PTR..BRANCH (op[2]==0) carry a meaningful mode bit.
    new_mode_s  = (new_op_s[2] == 1'b0) ? in_ix[0] : 1'b0;
    compat_s    = is_foldable(new_op_s) && (new_op_s == acc_op_q) &&
                  (new_mode_s == acc_mode_q);
    state_d     = state_q;
    acc_op_d    = acc_op_q;
    acc_mode_d  = acc_mode_q;
    acc_count_d = acc_count_q;
    in_ready_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          acc_op_d    = new_op_s;
          acc_mode_d  = new_mode_s;
          acc_count_d = CNT_ONE;
          if (is_foldable(new_op_s) && (CNT_ONE != CNT_MAX)) begin
            state_d = ST_ACC;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACC: begin
        in_ready_s = in_valid && compat_s && (acc_count_q != CNT_MAX);
        if (in_ready_s) begin
          acc_count_d = acc_count_q + CW'(1'b1);
          // Saturation closes the run; the next instruction starts afresh.
          if (acc_count_d == CNT_MAX) begin
            state_d = ST_EMIT;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          // Bubble or incompatible instruction: the latter stays at the input.
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        in_ready_s = out_ready && (acc_op_q != OP_STOP);
        if (out_ready) begin
          if (acc_op_q == OP_STOP) begin
            state_d = ST_HALT;
          end else if (in_valid) begin
            // Reload straight from the input so there is no idle bubble.
            acc_op_d    = new_op_s;
            acc_mode_d  = new_mode_s;
            acc_count_d = CNT_ONE;
            if (is_foldable(new_op_s) && (CNT_ONE != CNT_MAX)) begin
              state_d = ST_ACC;
            end else begin
              state_d = ST_EMIT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, accumulator and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_op_q    <= OP_PTR;
      acc_mode_q  <= 1'b0;
      acc_count_q <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_op_q    <= acc_op_d;
      acc_mode_q  <= acc_mode_d;
      acc_count_q <= acc_count_d;
      out_valid_q <= (state_d == ST_EMIT);
      halted_q    <= (state_d == ST_HALT);
    end
  end

  // in_ready must be low while reset is held, even though it is combinational.
  assign in_ready  = rst_n & in_ready_s;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign out_op    = acc_op_q;
  assign out_mode  = acc_mode_q;
  assign out_count = acc_count_q;

endmodule

// File: tb/tb_decode_fold.sv
`timescale 1ns/1ps
module tb_decode_fold;
  localparam int IW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [IW-1:0] in_ix;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_op;
  logic          out_mode;
  logic [CW-1:0] out_count;
  logic          halted;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] sb[$];
  logic        stall_r = 1'b0;
  logic [31:0] snap_r  = 32'd0;

  decode_fold #(.IW(IW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ix(in_ix), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_mode(out_mode), .out_count(out_count),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] op, input logic m, input logic [CW-1:0] c);
    return {24'd0, op, m, c};
  endfunction

  function automatic logic [31:0] obs_out();
    return {24'd0, out_op, out_mode, out_count};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, let the posedge pass.
  task automatic cyc(input logic v, input logic [7:0] ix, input logic ordy, output logic acc);
    logic [31:0] e;
    in_valid = v; in_ix = ix; out_ready = ordy;
    #1;
    if (stall_r) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_outputs", obs_out(), snap_r);
    end
    if (out_valid && out_ready) begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = 32'hDEAD_BEEF;
      chk("emit", obs_out(), e);
    end
    stall_r = out_valid && !out_ready;
    snap_r  = obs_out();
    acc = v && in_ready;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] ix, input logic ordy, output int tries);
    logic a;
    a = 1'b0; tries = 0;
    while (!a && tries < 20) begin
      cyc(1'b1, ix, ordy, a);
      tries++;
    end
    chk("send_accept", {31'd0, a}, 32'd1);
  endtask

  task automatic drain();
    logic a;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      cyc(1'b0, 8'h00, 1'b1, a);
      n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic a;
    int t;
    int first_try;
    rst_n = 1'b0; in_valid = 1'b0; in_ix = 8'h00; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_outputs", obs_out(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Fold with bubble.
    sb.push_back(mk(3'd1, 1'b1, 4'd3));
    repeat (3) send(8'h03, 1'b1, t);
    drain();

    // Saturation: 15 folds, then the 16th starts a new run.
    sb.push_back(mk(3'd0, 1'b1, 4'd15));
    sb.push_back(mk(3'd0, 1'b1, 4'd1));
    first_try = 0;
    for (int i = 0; i < 15; i++) begin
      send(8'h01, 1'b0, t);
      if (t == 1) first_try++;
    end
    chk("sat_contiguous", first_try, 32'd15);
    cyc(1'b1, 8'h01, 1'b0, a);
    chk("sat_in_ready", {31'd0, a}, 32'd0);
    send(8'h01, 1'b1, t);
    chk("sat_16th_with_emit", t, 32'd1);
    drain();

    // Mode break: the incompatible instruction waits one cycle.
    sb.push_back(mk(3'd1, 1'b1, 4'd1));
    sb.push_back(mk(3'd1, 1'b0, 4'd1));
    sb.push_back(mk(3'd0, 1'b0, 4'd1));
    send(8'h03, 1'b1, t);
    send(8'h02, 1'b1, t);
    chk("mode_break_hold", t, 32'd2);
    send(8'h00, 1'b1, t);
    chk("class_break_hold", t, 32'd2);
    drain();

    // Backpressure: outputs hold while out_ready is low.
    sb.push_back(mk(3'd2, 1'b1, 4'd1));
    sb.push_back(mk(3'd2, 1'b1, 4'd1));
    sb.push_back(mk(3'd3, 1'b1, 4'd1));
    send(8'h05, 1'b0, t);
    chk("io_latency", {31'd0, out_valid}, 32'd1);
    repeat (3) begin
      cyc(1'b1, 8'h05, 1'b0, a);
      chk("bp_in_ready", {31'd0, a}, 32'd0);
    end
    send(8'h05, 1'b1, t);
    send(8'h07, 1'b1, t);
    drain();

    // Stop / illegal.
    sb.push_back(mk(3'd7, 1'b0, 4'd1));
    sb.push_back(mk(3'd4, 1'b0, 4'd1));
    send(8'h0A, 1'b1, t);
    send(8'h08, 1'b1, t);
    cyc(1'b1, 8'h02, 1'b1, a);
    chk("stop_blocks_next", {31'd0, a}, 32'd0);
    repeat (2) begin
      cyc(1'b1, 8'h02, 1'b1, a);
      chk("halt_in_ready", {31'd0, a}, 32'd0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("stop_sb_empty", sb.size(), 32'd0);

    // Reset leaves HALT.
    rst_n = 1'b0;
    stall_r = 1'b0;
    #1;
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-ACC with count 2.
    send(8'h01, 1'b1, t);
    send(8'h01, 1'b1, t);
    #1;
    chk("acc_count_2", {28'd0, out_count}, 32'd2);
    chk("acc_no_valid", {31'd0, out_valid}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_count", {28'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    stall_r = 1'b0;
    @(negedge clk);
    sb.push_back(mk(3'd1, 1'b0, 4'd1));
    send(8'h02, 1'b1, t);
    drain();
    repeat (4) cyc(1'b0, 8'h00, 1'b1, a);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
